inv_key_schedule: RTL and testbench
===================================

Name: inv_key_schedule

Overview:
- Iterative inverse AES-128 key schedule for the decryption datapath.
- Accepts the final round key (rk10), then emits round keys rk10, rk9, …, rk0 one per handshake, computing each predecessor on the fly.
- Sits between key storage and the inverse-cipher round engine, so decryption needs no 11-entry key RAM.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128. Other values are unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when ready=1
- last_key  in  128  rk10; word0 = [127:96] … word3 = [31:0]; sampled with start
- ready  out  1  idle, can accept start
- rk_out  out  128  current round key
- rk_index  out  4  round number of rk_out (10 down to 0)
- rk_valid  out  1  rk_out/rk_index valid
- rk_ready  in  1  consumer accepts rk_out when rk_valid & rk_ready
- done  out  1  one-cycle pulse after rk0 is accepted

Behaviour:
- Reset (async, rst_n=0) values:
  - ready=1, rk_valid=0, done=0, rk_out=0, rk_index=0.
  - State = IDLE.
- States: IDLE, EMIT.
- IDLE:
  - ready=1.
  - On start=1 at a clock edge: load key_reg<=last_key, idx<=10, go to EMIT.
  - ready=0 from the next cycle.
- EMIT:
  - rk_valid=1, rk_out=key_reg, rk_index=idx.
  - Outputs stay stable while rk_ready=0; arbitrary stall length is allowed.
- Handshake in EMIT with idx>0: key_reg<=prev(key_reg, idx), idx<=idx-1, stay in EMIT. The new key is visible the next cycle.
- Handshake in EMIT with idx==0: go to IDLE, rk_valid<=0, done<=1 for exactly one cycle, ready<=1.
- Latency and throughput:
  - Start accepted at edge N → rk10 valid in cycle N+1.
  - With rk_ready held high, rk10..rk0 appear in 11 consecutive cycles.
  - done is high in cycle N+12.
- prev(key, i) with words w0..w3 (w0 = MSW):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {RCON[i],24'h0}
  - RotWord(x) = {x[23:0], x[31:24]}; SubWord applies the forward S-box per byte.
  - RCON[10..1] = 36,1b,80,40,20,10,08,04,02,01.
- start while not ready: ignored, with no effect on the current sequence.
- start in the same cycle done pulses: state is IDLE (ready=1), so start is accepted normally.
- rk_ready asserted in IDLE: ignored.
- Reset mid-sequence: immediately returns all outputs to reset values. No partial-key or done pulse after rst_n releases.
- idx never wraps: the idx==0 handshake exits to IDLE and never decrements.
- All state updates are on the clock edge. The combinational prev() path is one S-box deep plus XORs, with no multicycle paths.

Decomposition:
- Shared package aes_pkg:
  - RCON lookup (function of round index 1..10)
  - AES_NR=10 constant
  - Word-slice helpers / 32-bit word typedef
- Sub-module inv_key_step (combinational):
  - Inputs: key[127:0], round[3:0]. Output: prev_key[127:0].
  - Instantiates four existing sub_box byte S-boxes for SubWord(RotWord(w3')).
- Top level holds the FSM, idx counter, key_reg and the handshake logic.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, last_key = d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1:
  - rk10 appears the cycle after start; then rk9 = ac7766f319fadc2128d12941575c006e (idx 9).
  - rk1 = a0fafe1788542cb123a339392a6c7605; rk0 = 2b7e151628aed2a6abf7158809cf4f3c (idx 0).
  - done pulses once, 12 cycles after the start edge.
- Same vector with rk_ready toggled pseudo-randomly: identical key/index sequence, and rk_out stable during every stall.
- start pulsed while busy, at idx=5, with a different last_key: sequence unaffected, ready stays 0.
- rst_n driven low at idx=4, mid-stall:
  - Outputs go to reset values immediately.
  - After release, a new start with last_key = all zeros runs a full 11-key sequence.
  - Each key matches the software model, and done pulses once.
- Back-to-back: start asserted in the done cycle → accepted; rk10 valid the next cycle.
- rk_ready=1 held in IDLE with no start: rk_valid stays 0 and done never asserts over 50 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, the 32-bit word type and the round-constant lookup
// used by the inverse key schedule.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [31:0] word_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } ks_state_e;

    // Word 0 is the most significant word of the 128-bit key.
    function automatic word_t key_word(input logic [127:0] key, input int n);
        return key[127 - 32*n -: 32];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// Combinational one-round step of the inverse AES-128 key schedule:
// derives round key i-1 from round key i.
module inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] prev_key
);

    word_t w0, w1, w2, w3;
    word_t w0_n, w1_n, w2_n, w3_n;
    word_t rot_w, sub_w;

    assign w0 = key_word(key, 0);
    assign w1 = key_word(key, 1);
    assign w2 = key_word(key, 2);
    assign w3 = key_word(key, 3);

    assign w3_n = w3 ^ w2;
    assign w2_n = w2 ^ w1;
    assign w1_n = w1 ^ w0;

    // SubWord(RotWord()) is taken on the recovered w3 of the previous round.
    assign rot_w = {w3_n[23:0], w3_n[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sub_box u_sub_box (
            .in_byte  (rot_w[8*b +: 8]),
            .out_byte (sub_w[8*b +: 8])
        );
    end

    assign w0_n     = w0 ^ sub_w ^ {rcon(round), 24'h0};
    assign prev_key = {w0_n, w1_n, w2_n, w3_n};

endmodule

// File: rtl/sub_box.sv
// Forward AES S-box for a single byte, implemented as a constant lookup table.
module sub_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/inv_key_schedule.sv
// Emits AES-128 round keys rk10..rk0 one per handshake, regenerating each
// predecessor on the fly from the final round key.
//   state   | meaning
//   ST_IDLE | ready=1, waiting for start/last_key
//   ST_EMIT | rk_out/rk_index valid, advancing on each rk_ready handshake
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic         ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;
    logic [127:0] prev_key;

    inv_key_step u_inv_key_step (
        .key      (key_q),
        .round    (idx_q),
        .prev_key (prev_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    idx_d   = 4'(NR);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    // rk0 is terminal: leave without decrementing so idx never wraps.
                    if (idx_q != 4'd0) begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready    = (state_q == ST_IDLE);
    assign rk_valid = (state_q == ST_EMIT);
    assign rk_out   = key_q;
    assign rk_index = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: expected keys come from an independent
// forward key expansion (FIPS vector) or a software inverse model (zero key).
module tb_inv_key_schedule;

    localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] LAST_KEY   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK9        = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] RK1        = 128'ha0fafe1788542cb123a339392a6c7605;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [127:0] last_key;
    logic         ready, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [7:0]   sbox_t [256];
    logic [7:0]   rc [11];
    logic [127:0] exp_rk [11];
    logic [131:0] sb_q [$];

    logic         stall_q = 1'b0;
    logic [127:0] stall_key;
    logic [3:0]   stall_idx;

    inv_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .last_key (last_key),
        .ready    (ready),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box built from first principles: GF(2^8) inverse followed by the affine map.
    task automatic init_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_fwd(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic back_model(input logic [127:0] last);
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
        exp_rk[10] = last;
        for (int i = 10; i >= 1; i--) begin
            {w0, w1, w2, w3} = exp_rk[i];
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc[i], 24'h0};
            exp_rk[i-1] = {n0, n1, n2, n3};
        end
    endtask

    task automatic push_seq();
        for (int i = 10; i >= 0; i--) sb_q.push_back({4'(i), exp_rk[i]});
    endtask

    task automatic wc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        logic fin;
        fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            wc();
            if (done) fin = 1'b1;
        end
        chk(tag, 128'(fin), 128'd1);
    endtask

    always @(negedge clk) begin
        logic [131:0] e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (stall_q) begin
                chk("stall_key", rk_out, stall_key);
                chk("stall_idx", 128'(rk_index), 128'(stall_idx));
            end
            if (rk_valid && rk_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 128'd1, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_key", rk_out, e[127:0]);
                    chk("sb_idx", 128'(rk_index), 128'(e[131:128]));
                end
            end
            stall_q   = rk_valid && !rk_ready;
            stall_key = rk_out;
            stall_idx = rk_index;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        int  d0;
        logic busy_done, fin, seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        init_tables();
        repeat (2) wc();
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_key", rk_out, 128'd0);
        chk("rst_idx", 128'(rk_index), 128'd0);
        rst_n = 1'b1;
        wc();

        // FIPS-197 vector, rk_ready held high: exact cycle timing
        expand_fwd(CIPHER_KEY);
        push_seq();
        d0       = done_cnt;
        last_key = LAST_KEY;
        rk_ready = 1'b1;
        start    = 1'b1;
        wc();
        start = 1'b0;
        chk("n1_idx", 128'(rk_index), 128'd10);
        chk("n1_key", rk_out, LAST_KEY);
        chk("n1_ready", 128'(ready), 128'd0);
        wc();
        chk("rk9_key", rk_out, RK9);
        chk("rk9_idx", 128'(rk_index), 128'd9);
        repeat (8) wc();
        chk("rk1_key", rk_out, RK1);
        chk("rk1_idx", 128'(rk_index), 128'd1);
        wc();
        chk("rk0_key", rk_out, CIPHER_KEY);
        chk("rk0_idx", 128'(rk_index), 128'd0);
        chk("rk0_done", 128'(done), 128'd0);
        wc();
        chk("n12_done", 128'(done), 128'd1);
        chk("n12_ready", 128'(ready), 128'd1);
        chk("n12_valid", 128'(rk_valid), 128'd0);
        wc();
        chk("n13_done", 128'(done), 128'd0);
        chk("done_once", 128'(done_cnt - d0), 128'd1);
        chk("sb_drained", 128'(sb_q.size()), 128'd0);

        // random stalls plus a start pulse while busy at idx 5
        push_seq();
        d0        = done_cnt;
        last_key  = LAST_KEY;
        start     = 1'b1;
        wc();
        start     = 1'b0;
        busy_done = 1'b0;
        fin       = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            rk_ready = 1'($urandom_range(0, 1));
            if (!busy_done && rk_valid && rk_index == 4'd5) begin
                start     = 1'b1;
                last_key  = {$urandom, $urandom, $urandom, $urandom};
                busy_done = 1'b1;
                wc();
                start = 1'b0;
                chk("busy_ready", 128'(ready), 128'd0);
            end else begin
                wc();
            end
            if (done) fin = 1'b1;
        end
        chk("rand_fin", 128'(fin), 128'd1);
        chk("busy_hit", 128'(busy_done), 128'd1);
        wc();
        chk("rand_done_once", 128'(done_cnt - d0), 128'd1);
        chk("rand_drained", 128'(sb_q.size()), 128'd0);

        // reset asserted at idx 4 while stalled
        push_seq();
        last_key = LAST_KEY;
        rk_ready = 1'b1;
        start    = 1'b1;
        wc();
        start = 1'b0;
        fin   = 1'b0;
        for (int c = 0; c < 30 && !fin; c++) begin
            if (rk_index == 4'd4) fin = 1'b1;
            else wc();
        end
        chk("reach_idx4", 128'(fin), 128'd1);
        rk_ready = 1'b0;
        repeat (2) wc();
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", 128'(ready), 128'd1);
        chk("mrst_valid", 128'(rk_valid), 128'd0);
        chk("mrst_done", 128'(done), 128'd0);
        chk("mrst_key", rk_out, 128'd0);
        chk("mrst_idx", 128'(rk_index), 128'd0);
        sb_q.delete();
        wc();
        rst_n = 1'b1;
        d0    = done_cnt;
        rk_ready = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wc();
            if (rk_valid) seen = 1'b1;
        end
        chk("post_rst_valid", 128'(seen), 128'd0);
        chk("post_rst_done", 128'(done_cnt - d0), 128'd0);

        // all-zero last_key after reset
        back_model(128'd0);
        push_seq();
        last_key = '0;
        start    = 1'b1;
        wc();
        start = 1'b0;
        chk("zero_n1_idx", 128'(rk_index), 128'd10);
        run_until_done(30, "zero_fin");

        // back-to-back: start in the done cycle
        expand_fwd(CIPHER_KEY);
        push_seq();
        chk("b2b_ready", 128'(ready), 128'd1);
        last_key = LAST_KEY;
        start    = 1'b1;
        wc();
        start = 1'b0;
        chk("b2b_valid", 128'(rk_valid), 128'd1);
        chk("b2b_idx", 128'(rk_index), 128'd10);
        chk("b2b_key", rk_out, LAST_KEY);
        run_until_done(30, "b2b_fin");
        wc();
        chk("b2b_done_cnt", 128'(done_cnt - d0), 128'd2);
        chk("b2b_drained", 128'(sb_q.size()), 128'd0);

        // idle with rk_ready high and no start
        d0   = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            wc();
            if (rk_valid) seen = 1'b1;
        end
        chk("idle_valid", 128'(seen), 128'd0);
        chk("idle_done", 128'(done_cnt - d0), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
